osd_cmd_tx: RTL and testbench

OSD_CMD_TX -- requirements
Module: osd_cmd_tx

---
 rtl/osd_pkg.sv | 52 +++++
 rtl/osd_strobe_gen.sv | 53 +++++
 rtl/osd_cmd_tx.sv | 192 +++++++++++++++++++
 tb/tb_osd_cmd_tx.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/osd_pkg.sv
// rtl/osd_pkg.sv - op codes, command bytes, state encoding and word builders for the OSD transmitter
package osd_pkg;

  typedef enum logic [1:0] {
    OP_DISABLE     = 2'd0,
    OP_ENABLE      = 2'd1,
    OP_ENABLE_INFO = 2'd2,
    OP_WRITE_LINE  = 2'd3
  } osd_op_e;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CMD   = 3'd1,
    ST_PARAM = 3'd2,
    ST_FETCH = 3'd3,
    ST_DATA  = 3'd4,
    ST_GAP   = 3'd5
  } osd_state_e;

  localparam logic [7:0] CMD_WRITE_LINE  = 8'h20;
  localparam logic [7:0] CMD_DISABLE     = 8'h40;
  localparam logic [7:0] CMD_ENABLE      = 8'h41;
  localparam logic [7:0] CMD_ENABLE_INFO = 8'h45;

  localparam int PARAM_WORDS = 5;

  function automatic logic [15:0] cmd_word(input osd_op_e op, input logic [4:0] line);
    case (op)
      OP_DISABLE:     cmd_word = {8'h00, CMD_DISABLE};
      OP_ENABLE:      cmd_word = {8'h00, CMD_ENABLE};
      OP_ENABLE_INFO: cmd_word = {8'h00, CMD_ENABLE_INFO};
      default:        cmd_word = {8'h00, CMD_WRITE_LINE | {3'b000, line}};
    endcase
  endfunction

  // Sizes arrive already divided by 8 (the receiver counts in 8-pixel units).
  function automatic logic [15:0] param_word(input logic [2:0] idx,
                                             input logic [11:0] x,
                                             input logic [11:0] y,
                                             input logic [5:0] w8,
                                             input logic [5:0] h8,
                                             input logic [1:0] rot);
    case (idx)
      3'd0:    param_word = {4'b0, x};
      3'd1:    param_word = {4'b0, y};
      3'd2:    param_word = {10'b0, w8};
      3'd3:    param_word = {10'b0, h8};
      default: param_word = {14'b0, rot};
    endcase
  endfunction

endpackage

// File: rtl/osd_strobe_gen.sv
// rtl/osd_strobe_gen.sv - one word slot: strobe low 1 cycle, high STROBE_HI, low STROBE_LO
module osd_strobe_gen #(
  parameter int STROBE_HI = 2,
  parameter int STROBE_LO = 2
) (
  input  logic clk_sys,
  input  logic reset,
  input  logic start,
  output logic io_strobe,
  output logic slot_done
);

  localparam int SLOT_LAST = STROBE_HI + STROBE_LO;
  localparam int CW = $clog2(SLOT_LAST + 1);
  localparam logic [CW-1:0] HI_END = CW'(STROBE_HI);
  localparam logic [CW-1:0] LAST   = CW'(SLOT_LAST);
  localparam logic [CW-1:0] ONE    = CW'(1);

  logic          active_q, active_n;
  logic [CW-1:0] cnt_q, cnt_n;

  // cnt is the slot cycle index; the start cycle itself is index 0
  always_comb begin
    active_n = active_q;
    cnt_n    = cnt_q;
    if (active_q) begin
      if (cnt_q == LAST) begin
        active_n = 1'b0;
        cnt_n    = '0;
      end else begin
        cnt_n = cnt_q + ONE;
      end
    end else if (start) begin
      active_n = 1'b1;
      cnt_n    = ONE;
    end
  end

  assign slot_done = active_q && (cnt_q == LAST);

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      active_q  <= 1'b0;
      cnt_q     <= '0;
      io_strobe <= 1'b0;
    end else begin
      active_q  <= active_n;
      cnt_q     <= cnt_n;
      io_strobe <= active_n && (cnt_n <= HI_END);
    end
  end

endmodule

// File: rtl/osd_cmd_tx.sv
// rtl/osd_cmd_tx.sv - serialises OSD commands, parameters and line data as strobed 16-bit words
module osd_cmd_tx
  import osd_pkg::*;
#(
  parameter int STROBE_HI = 2,
  parameter int STROBE_LO = 2,
  parameter int GAP_CYC   = 4
) (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [1:0]  req_op,
  input  logic [4:0]  req_line,
  input  logic [11:0] req_infox,
  input  logic [11:0] req_infoy,
  input  logic [8:0]  req_infow,
  input  logic [8:0]  req_infoh,
  input  logic [1:0]  req_rot,
  output logic [7:0]  rd_addr,
  output logic        rd_en,
  input  logic [7:0]  rd_data,
  output logic        io_osd,
  output logic        io_strobe,
  output logic [15:0] io_din,
  output logic        busy
);

  localparam int GW = $clog2(GAP_CYC + 1);
  localparam logic [GW-1:0] GAP_LAST   = GW'(GAP_CYC - 1);
  localparam logic [GW-1:0] GAP_ONE    = GW'(1);
  localparam logic [2:0]    PARAM_LAST = 3'(PARAM_WORDS - 1);

  osd_state_e  state_q, state_n;
  osd_op_e     op_q;
  logic [4:0]  line_q;
  logic [11:0] infox_q, infoy_q;
  logic [5:0]  infow_q, infoh_q;
  logic [1:0]  rot_q;
  logic [2:0]  pidx_q, pidx_n;
  logic        fetch_ph_q, fetch_ph_n;
  logic [7:0]  rd_addr_q, rd_addr_n;
  logic [15:0] din_q, din_n;
  logic [GW-1:0] gcnt_q, gcnt_n;
  logic        start_q, start_n;
  logic        slot_done;
  logic        accept;
  logic        unused_bits;

  assign unused_bits = ^{req_infow[2:0], req_infoh[2:0]};

  assign req_ready = (state_q == ST_IDLE) && !reset;
  assign accept    = req_valid && req_ready;
  assign busy      = (state_q != ST_IDLE);
  assign io_osd    = (state_q != ST_IDLE) && (state_q != ST_GAP);
  assign rd_en     = (state_q == ST_FETCH) && !fetch_ph_q;
  assign rd_addr   = rd_addr_q;
  assign io_din    = din_q;

  osd_strobe_gen #(
    .STROBE_HI (STROBE_HI),
    .STROBE_LO (STROBE_LO)
  ) u_strobe (
    .clk_sys   (clk_sys),
    .reset     (reset),
    .start     (start_q),
    .io_strobe (io_strobe),
    .slot_done (slot_done)
  );

  // start_n marks the first cycle of every word slot; din_n is loaded alongside it
  always_comb begin
    state_n    = state_q;
    pidx_n     = pidx_q;
    fetch_ph_n = fetch_ph_q;
    rd_addr_n  = rd_addr_q;
    din_n      = din_q;
    gcnt_n     = gcnt_q;
    start_n    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          state_n = ST_CMD;
          start_n = 1'b1;
          din_n   = cmd_word(osd_op_e'(req_op), req_line);
        end
      end
      ST_CMD: begin
        if (slot_done) begin
          case (op_q)
            OP_ENABLE_INFO: begin
              state_n = ST_PARAM;
              pidx_n  = 3'd0;
              start_n = 1'b1;
              din_n   = param_word(3'd0, infox_q, infoy_q, infow_q, infoh_q, rot_q);
            end
            OP_WRITE_LINE: begin
              state_n    = ST_FETCH;
              fetch_ph_n = 1'b0;
              rd_addr_n  = 8'd0;
            end
            default: begin
              state_n = ST_GAP;
              din_n   = 16'd0;
              gcnt_n  = '0;
            end
          endcase
        end
      end
      ST_PARAM: begin
        if (slot_done) begin
          if (pidx_q == PARAM_LAST) begin
            state_n = ST_GAP;
            din_n   = 16'd0;
            gcnt_n  = '0;
          end else begin
            pidx_n  = pidx_q + 3'd1;
            start_n = 1'b1;
            din_n   = param_word(pidx_q + 3'd1, infox_q, infoy_q, infow_q, infoh_q, rot_q);
          end
        end
      end
      ST_FETCH: begin
        // phase 0 issues the read, phase 1 captures the byte one cycle later
        if (!fetch_ph_q) begin
          fetch_ph_n = 1'b1;
        end else begin
          fetch_ph_n = 1'b0;
          state_n    = ST_DATA;
          start_n    = 1'b1;
          din_n      = {8'h00, rd_data};
        end
      end
      ST_DATA: begin
        if (slot_done) begin
          rd_addr_n = rd_addr_q + 8'd1;
          if (rd_addr_q == 8'hFF) begin
            state_n = ST_GAP;
            din_n   = 16'd0;
            gcnt_n  = '0;
          end else begin
            state_n = ST_FETCH;
          end
        end
      end
      ST_GAP: begin
        if (gcnt_q == GAP_LAST) begin
          state_n = ST_IDLE;
        end else begin
          gcnt_n = gcnt_q + GAP_ONE;
        end
      end
      default: begin
        state_n = ST_IDLE;
        din_n   = 16'd0;
      end
    endcase
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      pidx_q     <= 3'd0;
      fetch_ph_q <= 1'b0;
      rd_addr_q  <= 8'd0;
      din_q      <= 16'd0;
      gcnt_q     <= '0;
      start_q    <= 1'b0;
    end else begin
      state_q    <= state_n;
      pidx_q     <= pidx_n;
      fetch_ph_q <= fetch_ph_n;
      rd_addr_q  <= rd_addr_n;
      din_q      <= din_n;
      gcnt_q     <= gcnt_n;
      start_q    <= start_n;
    end
  end

  always_ff @(posedge clk_sys) begin
    if (accept) begin
      op_q    <= osd_op_e'(req_op);
      line_q  <= req_line;
      infox_q <= req_infox;
      infoy_q <= req_infoy;
      infow_q <= req_infow[8:3];
      infoh_q <= req_infoh[8:3];
      rot_q   <= req_rot;
    end
  end

endmodule

// File: tb/tb_osd_cmd_tx.sv
// tb/tb_osd_cmd_tx.sv - directed and randomized checks of osd_cmd_tx against a word-list model
module tb_osd_cmd_tx;

  logic clk_sys = 1'b0;
  always #5 clk_sys = ~clk_sys;

  logic        reset;
  logic        req_valid_a, req_valid_b;
  logic [1:0]  req_op;
  logic [4:0]  req_line;
  logic [11:0] req_infox, req_infoy;
  logic [8:0]  req_infow, req_infoh;
  logic [1:0]  req_rot;

  logic        req_ready_a, rd_en_a, io_osd_a, io_strobe_a, busy_a;
  logic [7:0]  rd_addr_a, rd_data_a;
  logic [15:0] io_din_a;
  logic        req_ready_b, rd_en_b, io_osd_b, io_strobe_b, busy_b;
  logic [7:0]  rd_addr_b, rd_data_b;
  logic [15:0] io_din_b;

  osd_cmd_tx dut_a (
    .clk_sys(clk_sys), .reset(reset), .req_valid(req_valid_a), .req_ready(req_ready_a),
    .req_op(req_op), .req_line(req_line), .req_infox(req_infox), .req_infoy(req_infoy),
    .req_infow(req_infow), .req_infoh(req_infoh), .req_rot(req_rot),
    .rd_addr(rd_addr_a), .rd_en(rd_en_a), .rd_data(rd_data_a),
    .io_osd(io_osd_a), .io_strobe(io_strobe_a), .io_din(io_din_a), .busy(busy_a)
  );

  osd_cmd_tx #(.STROBE_HI(1), .STROBE_LO(1), .GAP_CYC(4)) dut_b (
    .clk_sys(clk_sys), .reset(reset), .req_valid(req_valid_b), .req_ready(req_ready_b),
    .req_op(req_op), .req_line(req_line), .req_infox(req_infox), .req_infoy(req_infoy),
    .req_infow(req_infow), .req_infoh(req_infoh), .req_rot(req_rot),
    .rd_addr(rd_addr_b), .rd_en(rd_en_b), .rd_data(rd_data_b),
    .io_osd(io_osd_b), .io_strobe(io_strobe_b), .io_din(io_din_b), .busy(busy_b)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Line buffer: byte valid exactly one cycle after rd_en, junk otherwise
  logic [7:0] mem [256];
  always @(posedge clk_sys) rd_data_a <= rd_en_a ? mem[rd_addr_a] : 8'($urandom);
  always @(posedge clk_sys) rd_data_b <= 8'($urandom);

  int hi_exp[2]   = '{2, 1};
  int slot_len[2] = '{5, 3};

  logic        started;
  logic        stb_p[2], osd_p[2];
  logic [15:0] din_p[2];
  bit          rise_ok[2];
  int          rise_cyc[2], osd_cyc[2], frame_rises[2], low_run[2], last_low[2];
  int          cyc;
  logic [15:0] cap_q[$];
  int          ivl_q[$];
  int          frame_log[$];
  logic [7:0]  exp_addr;
  int          rd_cnt;
  logic        m_s, m_o;
  logic [15:0] m_d;

  always @(negedge clk_sys) begin
    if (started) begin
      for (int i = 0; i < 2; i++) begin
        m_s = (i == 0) ? io_strobe_a : io_strobe_b;
        m_o = (i == 0) ? io_osd_a : io_osd_b;
        m_d = (i == 0) ? io_din_a : io_din_b;
        if (m_o && !osd_p[i]) begin
          osd_cyc[i] = cyc;
          frame_rises[i] = 0;
          last_low[i] = low_run[i];
        end
        if (!m_o && osd_p[i]) begin
          frame_log.push_back(frame_rises[i]);
          rise_ok[i] = 1'b0;
        end
        if (m_s && !stb_p[i]) begin
          cap_q.push_back(m_d);
          chk("din_stable_at_rise", m_d, din_p[i]);
          if (rise_ok[i]) ivl_q.push_back(cyc - rise_cyc[i]);
          else chk("osd_leads_strobe", 32'(cyc - osd_cyc[i] >= 1), 1);
          rise_ok[i] = 1'b1;
          rise_cyc[i] = cyc;
          frame_rises[i]++;
        end
        if (!m_s && stb_p[i] && !reset) chk("strobe_hi_len", cyc - rise_cyc[i], hi_exp[i]);
        if (!m_o) chk("din_zero_no_frame", m_d, 0);
        low_run[i] = m_o ? 0 : low_run[i] + 1;
        stb_p[i] = m_s;
        osd_p[i] = m_o;
        din_p[i] = m_d;
      end
      if (rd_en_a) begin
        chk("rd_addr_seq", rd_addr_a, exp_addr);
        exp_addr = exp_addr + 8'd1;
        rd_cnt++;
      end
    end
    cyc++;
  end

  function automatic logic ready_of(input int sel);
    return (sel == 0) ? req_ready_a : req_ready_b;
  endfunction
  function automatic logic osd_of(input int sel);
    return (sel == 0) ? io_osd_a : io_osd_b;
  endfunction
  function automatic logic busy_of(input int sel);
    return (sel == 0) ? busy_a : busy_b;
  endfunction

  task automatic send(input int sel, input logic [1:0] op, input logic [4:0] line,
                      input logic [11:0] x, input logic [11:0] y,
                      input logic [8:0] w, input logic [8:0] h, input logic [1:0] rot);
    int n;
    @(negedge clk_sys);
    req_op = op; req_line = line; req_infox = x; req_infoy = y;
    req_infow = w; req_infoh = h; req_rot = rot;
    if (sel == 0) req_valid_a = 1'b1; else req_valid_b = 1'b1;
    n = 0;
    while (ready_of(sel) !== 1'b1 && n < 50) begin @(negedge clk_sys); n++; end
    chk("accept_wait", 32'(n < 50), 1);
    @(negedge clk_sys);
    req_valid_a = 1'b0;
    req_valid_b = 1'b0;
    chk("busy_after_accept", busy_of(sel), 1);
    chk("ready_low_when_busy", ready_of(sel), 0);
  endtask

  // Waits out the frame, then returns how many cycles passed before req_ready
  task automatic finish_txn(input int sel, output int g);
    int n;
    n = 0;
    while (osd_of(sel) === 1'b1 && n < 4000) begin @(negedge clk_sys); n++; end
    chk("frame_end", 32'(n < 4000), 1);
    g = 0;
    while (ready_of(sel) !== 1'b1 && g < 50) begin
      chk("gap_osd_low", osd_of(sel), 0);
      g++;
      @(negedge clk_sys);
    end
  endtask

  task automatic run_txn(input int sel, input logic [1:0] op, input logic [4:0] line,
                         input logic [11:0] x, input logic [11:0] y,
                         input logic [8:0] w, input logic [8:0] h, input logic [1:0] rot);
    logic [15:0] exp_q[$];
    int g;
    case (op)
      2'd0: exp_q.push_back(16'h0040);
      2'd1: exp_q.push_back(16'h0041);
      2'd2: begin
        exp_q.push_back(16'h0045);
        exp_q.push_back(16'(x));
        exp_q.push_back(16'(y));
        exp_q.push_back(16'(w / 8));
        exp_q.push_back(16'(h / 8));
        exp_q.push_back(16'(rot));
      end
      default: begin
        exp_q.push_back(16'(32 + line));
        for (int a = 0; a < 256; a++) exp_q.push_back(16'(mem[a]));
      end
    endcase
    cap_q.delete(); ivl_q.delete(); frame_log.delete();
    exp_addr = 8'd0; rd_cnt = 0;
    send(sel, op, line, x, y, w, h, rot);
    finish_txn(sel, g);
    chk("gap_len", g, 4);
    chk("word_count", cap_q.size(), exp_q.size());
    for (int k = 0; k < exp_q.size() && k < cap_q.size(); k++) chk("word", cap_q[k], exp_q[k]);
    chk("frame_count", frame_log.size(), 1);
    if (frame_log.size() > 0) chk("rises_in_frame", frame_log[0], exp_q.size());
    foreach (ivl_q[k]) chk("slot_spacing", ivl_q[k], (op == 2'd3) ? slot_len[sel] + 2 : slot_len[sel]);
    if (op == 2'd3) begin
      chk("rd_count", rd_cnt, 256);
      chk("rd_addr_wrap", rd_addr_a, 0);
    end
  endtask

  initial begin
    int acc, n, g;
    started = 1'b0;
    cyc = 0;
    for (int i = 0; i < 2; i++) begin
      stb_p[i] = 1'b0; osd_p[i] = 1'b0; din_p[i] = 16'd0; rise_ok[i] = 1'b0;
      rise_cyc[i] = 0; osd_cyc[i] = 0; frame_rises[i] = 0; low_run[i] = 0; last_low[i] = 0;
    end
    exp_addr = 8'd0; rd_cnt = 0;
    reset = 1'b1; req_valid_a = 1'b0; req_valid_b = 1'b0;
    req_op = 2'd0; req_line = 5'd0; req_infox = 12'd0; req_infoy = 12'd0;
    req_infow = 9'd0; req_infoh = 9'd0; req_rot = 2'd0;
    for (int a = 0; a < 256; a++) mem[a] = 8'(a) ^ 8'hA5;

    repeat (3) @(negedge clk_sys);
    chk("rst_osd", io_osd_a, 0);
    chk("rst_strobe", io_strobe_a, 0);
    chk("rst_din", io_din_a, 0);
    chk("rst_rd_en", rd_en_a, 0);
    chk("rst_rd_addr", rd_addr_a, 0);
    chk("rst_busy", busy_a, 0);
    chk("rst_osd_b", io_osd_b, 0);
    reset = 1'b0;
    @(negedge clk_sys);
    chk("ready_after_reset", req_ready_a, 1);
    started = 1'b1;

    run_txn(0, 2'd1, 5'd0, 12'd0, 12'd0, 9'd0, 9'd0, 2'd0);
    run_txn(0, 2'd2, 5'd0, 12'd100, 12'd50, 9'd128, 9'd64, 2'd1);
    run_txn(0, 2'd3, 5'd9, 12'd0, 12'd0, 9'd0, 9'd0, 2'd0);

    // Two DISABLEs with req_valid held: second must wait out the gap
    cap_q.delete(); frame_log.delete();
    @(negedge clk_sys);
    req_op = 2'd0; req_valid_a = 1'b1;
    acc = 0; n = 0;
    while (acc < 2 && n < 200) begin
      if (req_ready_a === 1'b1) begin
        acc++;
        chk("ready_only_idle", busy_a, 0);
      end
      @(negedge clk_sys);
      n++;
    end
    req_valid_a = 1'b0;
    chk("b2b_accepts", acc, 2);
    finish_txn(0, g);
    chk("b2b_gap_len", g, 4);
    chk("b2b_frames", frame_log.size(), 2);
    chk("b2b_low_between", last_low[0], 5);
    chk("b2b_words", cap_q.size(), 2);
    if (cap_q.size() == 2) begin
      chk("b2b_word0", cap_q[0], 16'h0040);
      chk("b2b_word1", cap_q[1], 16'h0040);
    end

    for (int t = 0; t < 6; t++) begin
      run_txn(0, 2'($urandom_range(0, 2)), 5'($urandom), 12'($urandom), 12'($urandom),
              9'($urandom_range(0, 63) * 8), 9'($urandom_range(0, 63) * 8), 2'($urandom));
    end
    for (int a = 0; a < 256; a++) mem[a] = 8'($urandom);
    run_txn(0, 2'd3, 5'($urandom), 12'd0, 12'd0, 9'd0, 9'd0, 2'd0);

    run_txn(1, 2'd2, 5'd0, 12'd100, 12'd50, 9'd128, 9'd64, 2'd1);
    run_txn(1, 2'd2, 5'd0, 12'($urandom), 12'($urandom),
            9'($urandom_range(0, 63) * 8), 9'($urandom_range(0, 63) * 8), 2'($urandom));

    // Abort during data word 100
    for (int a = 0; a < 256; a++) mem[a] = 8'($urandom);
    cap_q.delete(); exp_addr = 8'd0;
    send(0, 2'd3, 5'd3, 12'd0, 12'd0, 9'd0, 9'd0, 2'd0);
    n = 0;
    while (cap_q.size() < 102 && n < 2000) begin @(negedge clk_sys); n++; end
    chk("reach_word100", 32'(n < 2000), 1);
    reset = 1'b1;
    @(negedge clk_sys);
    chk("abort_osd", io_osd_a, 0);
    chk("abort_strobe", io_strobe_a, 0);
    chk("abort_rd_en", rd_en_a, 0);
    chk("abort_busy", busy_a, 0);
    chk("abort_din", io_din_a, 0);
    reset = 1'b0;
    @(negedge clk_sys);
    chk("ready_after_abort", req_ready_a, 1);
    run_txn(0, 2'd1, 5'd0, 12'd0, 12'd0, 9'd0, 9'd0, 2'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
